// File: rtl/click_pkg.sv
// Shared types and defaults for the click-pipeline receive bridge.
package click_pkg;

  localparam int unsigned DEF_BW_DATA = 8;
  localparam int unsigned DEF_DEPTH   = 4;

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    CAPT
  } state_e;

  // Pointer width: one extra wrap bit beyond the FIFO index.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/click_sync.sv
// Reset-to-zero flop chain; the only point where the asynchronous request is sampled.
module click_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/click_rx_bridge.sv
// Bridges a 2-phase bundled-data click stage into a synchronous valid/ready stream.
module click_rx_bridge
  import click_pkg::*;
#(
  parameter  int unsigned BW_DATA     = DEF_BW_DATA,
  parameter  int unsigned DEPTH       = DEF_DEPTH,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned PW          = ptr_w(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_reqL,
  input  logic [BW_DATA-1:0] i_data,
  output logic               o_ackL,
  output logic               o_valid,
  output logic [BW_DATA-1:0] o_data,
  input  logic               i_ready,
  output logic [PW-1:0]      o_count,
  output logic               o_full
);

  localparam int unsigned AW = PW - 1;

  state_e             state_q, state_d;
  logic               ack_q, ack_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               valid_q, valid_d;
  logic               full_q, full_d;
  logic [PW-1:0]      count_q, count_d;
  logic [BW_DATA-1:0] data_q, data_d;
  logic [BW_DATA-1:0] mem_q [DEPTH];
  logic               req_s;
  logic               pending;
  logic               wr_en;
  logic               rd_en;

  click_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (i_clk),
    .rst_ni (i_rstn),
    .async_i(i_reqL),
    .sync_o (req_s)
  );

  assign pending = req_s != ack_q;

  // Handshake FSM plus FIFO pointer / registered-flag next state.
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    wr_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;

    unique case (state_q)
      IDLE: begin
        if (pending) begin
          state_d = full_q ? STALL : CAPT;
        end
      end
      STALL: begin
        if (!full_q) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        wr_en   = 1'b1;
        ack_d   = ~ack_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_en = valid_q & i_ready;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    count_d = wr_ptr_d - rd_ptr_d;
    valid_d = wr_ptr_d != rd_ptr_d;
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
              (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    // Head bypass: a write landing on the new head slot is visible immediately.
    if (wr_en && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      data_d = i_data;
    end else if (rd_en) begin
      data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end
  end

  assign o_ackL  = ack_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_count = count_q;
  assign o_full  = full_q;

endmodule

// File: doc/click_rx_bridge.md
# click_rx_bridge

Receiving end of a click-element pipeline: converts the 2-phase bundled-data request/acknowledge protocol from the last click stage into a synchronous valid/ready stream in a single clock domain. It synchronizes the incoming request, captures the bundled data into a small FIFO, and returns a 2-phase acknowledge. It sits directly downstream of a click stage: the stage's `out_reqR` drives `i_reqL`, and `o_ackL` drives the stage's `in_ackR`.

## Interface
- `BW_DATA`, 8: width of bundled data word.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: flops in request synchronizer; ≥2.
- `i_clk`  input  1  single clock; all state on rising edge.
- `i_rstn`  input  1  asynchronous, active-low reset.
- `i_reqL`  input  1  2-phase request from the upstream click stage; asynchronous to `i_clk`.
- `i_data`  input  BW_DATA  bundled data; stable from the `i_reqL` toggle until the `o_ackL` toggle.
- `o_ackL`  output  1  2-phase acknowledge to the upstream stage; registered.
- `o_valid`  output  1  FIFO head valid (not empty).
- `o_data`  output  BW_DATA  FIFO head word (show-ahead).
- `i_ready`  input  1  consumer accepts head when `o_valid & i_ready`.
- `o_count`  output  $clog2(DEPTH)+1  occupancy.
- `o_full`  output  1  count == DEPTH.

## Operation
- Synchronizer: `i_reqL` passes through SYNC_STAGES flops to produce `req_s`. A token is pending when `req_s != ack_r`; `o_ackL = ack_r`.
- FSM states:
  - IDLE: pending & !full -> CAPT; pending & full -> STALL; otherwise stay.
  - STALL: leave for CAPT on the first cycle !full; no ack while stalled.
  - CAPT: write `i_data` at `wr_ptr`, toggle `ack_r`, -> IDLE. Exactly one write per CAPT.
- FIFO: read and write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Empty when the pointers are equal. Full when the MSBs differ and the remaining bits are equal.
- Read: on `o_valid & i_ready`, advance `rd_ptr`. `i_ready` while empty is ignored.
- Simultaneous write (CAPT) and read: both pointers advance and count is unchanged.
- Overflow is impossible. Entering CAPT requires !full, and count can only fall before the write.
- No false second capture: after the `ack_r` toggle, `req_s == ack_r` until upstream toggles again, because the synchronizer only lags.
- Reset values: `ack_r`=0, synchronizer flops=0, state IDLE, pointers 0, `o_valid`=0, `o_count`=0, `o_full`=0, `o_data`=0. FIFO storage is not reset.
- Reset mid-operation clears all state and any buffered tokens. Upstream must be reset together with this block (req phase 0). If `i_reqL`=1 at reset release, the bridge treats it as a pending token and captures it.

## Timing
- Latency: an `i_reqL` toggle meeting setup before edge 0 gives `req_s` changed after edge SYNC_STAGES−1. The FSM enters CAPT at edge SYNC_STAGES. At edge SYNC_STAGES+1, `o_ackL` toggles and `o_valid` rises if the FIFO was empty. With defaults this is 3 edges.
- `o_data` is valid in the same cycle as `o_valid`. The head changes only on the edge after a read.
- Throughput bound: one token per (SYNC_STAGES+2) cycles plus upstream response time.
- Data capture: `i_data` is sampled only on the CAPT edge, i.e. at least SYNC_STAGES cycles after the request. The bundling constraint is met by protocol.
- Full stall: `o_ackL` toggles exactly 2 edges after the read that frees a slot (STALL->CAPT, then CAPT write).

## Structure
- Package `click_pkg`:
  - state enum {IDLE, STALL, CAPT};
  - default `BW_DATA` and `DEPTH` constants;
  - pointer-width function.
- Sub-module `click_sync`: an N-stage reset-to-0 flop chain parameterized by SYNC_STAGES. It is the only place the asynchronous input is sampled.
- FIFO storage and pointers stay inline, along with the FSM.

## Test plan
- Reset, then one token: toggle `i_reqL` 0->1 with `i_data`=0xA5 -> `o_ackL` 0->1 and `o_valid`=1, `o_data`=0xA5 three edges later; `o_count`=1.
- Four tokens 0x01..0x04 with `i_ready`=0 -> `o_full`=1 and `o_count`=4. A fifth toggle (0x05) holds `o_ackL` and the FSM in STALL. One read -> `o_ackL` toggles 2 edges later and 0x05 enters the FIFO at the tail.
- Streaming with `i_ready`=1 and upstream responding immediately to the ack: 16 tokens 0x10..0x1F -> read in order, no loss or duplication; `o_count` never exceeds 1.
- Read and write on the same edge at `o_count`=2 -> `o_count` stays 2 and order is preserved.
- `i_rstn` low while 3 tokens are buffered and the FSM is in CAPT -> next cycle all outputs are 0. Release with `i_reqL`=0 -> no capture.
- Release reset with `i_reqL` held at 1 -> one capture occurs and `o_ackL` toggles to 1.
